// File: rtl/bypass_net_if.sv
// Issue/bypass bundle between the issue stage and the operand-forwarding network.
interface bypass_net_if #(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned NSTAGE  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5
);
  logic                             pipe_en;
  logic                             flush;
  logic [ISSUE_W-1:0]               issue_valid;
  logic [ISSUE_W*REG_AW-1:0]        issue_ra1;
  logic [ISSUE_W*REG_AW-1:0]        issue_ra2;
  logic [ISSUE_W*REG_AW-1:0]        issue_rdst;
  logic [ISSUE_W-1:0]               issue_regwrite;
  logic [ISSUE_W-1:0]               issue_late;
  logic [NSTAGE*ISSUE_W*DATA_W-1:0] stage_data;
  logic [ISSUE_W-1:0]               fwd_hit1;
  logic [ISSUE_W-1:0]               fwd_hit2;
  logic [ISSUE_W*DATA_W-1:0]        fwd_data1;
  logic [ISSUE_W*DATA_W-1:0]        fwd_data2;
  logic [ISSUE_W-1:0]               issue_ok;
  logic                             stall;

  modport master (
    output pipe_en, flush, issue_valid, issue_ra1, issue_ra2, issue_rdst,
           issue_regwrite, issue_late, stage_data,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, issue_ok, stall
  );

  modport slave (
    input  pipe_en, flush, issue_valid, issue_ra1, issue_ra2, issue_rdst,
           issue_regwrite, issue_late, stage_data,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, issue_ok, stall
  );
endinterface

// File: rtl/bypass_net.sv
// Operand-forwarding network: tracks in-flight destination tags per stage, resolves
// both sources of each issue slot against the youngest producer and grants issue in order.
module bypass_net #(
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned NSTAGE     = 4,
  parameter int unsigned LATE_STAGE = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5
) (
  input  logic          clk,
  input  logic          resetn,
  bypass_net_if.slave   bus
);

  typedef struct packed {
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } res_t;

  logic [NSTAGE-1:0][ISSUE_W-1:0]             r_valid;
  logic [NSTAGE-1:0][ISSUE_W-1:0]             r_regwrite;
  logic [NSTAGE-1:0][ISSUE_W-1:0]             r_late;
  logic [NSTAGE-1:0][ISSUE_W-1:0][REG_AW-1:0] r_rdst;

  logic [NSTAGE*ISSUE_W-1:0][DATA_W-1:0] w_sd;
  logic [ISSUE_W-1:0][REG_AW-1:0]        w_ra1, w_ra2, w_rdst;
  logic [ISSUE_W-1:0]                    w_hit1, w_hit2, w_rdy1, w_rdy2;
  logic [ISSUE_W-1:0][DATA_W-1:0]        w_data1, w_data2;
  logic [ISSUE_W-1:0]                    w_raw, w_ok;

  assign w_sd   = bus.stage_data;
  assign w_ra1  = bus.issue_ra1;
  assign w_ra2  = bus.issue_ra2;
  assign w_rdst = bus.issue_rdst;

  // Scan oldest stage first and lowest slot first so the last match is the youngest producer.
  function automatic res_t resolve(input logic [REG_AW-1:0] ra);
    res_t              res;
    logic              found;
    logic              late;
    logic [DATA_W-1:0] d;
    int unsigned       s;
    res.hit  = 1'b0;
    res.rdy  = 1'b1;
    res.data = '0;
    found    = 1'b0;
    late     = 1'b0;
    d        = '0;
    for (int unsigned n = 0; n < NSTAGE; n++) begin
      s = NSTAGE - 1 - n;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        if (r_valid[s][k] && r_regwrite[s][k] && (r_rdst[s][k] == ra) && (ra != '0)) begin
          found = 1'b1;
          late  = r_late[s][k] && (s < LATE_STAGE);
          d     = w_sd[s*ISSUE_W+k];
        end
      end
    end
    if (found) begin
      if (late) begin
        res.rdy = 1'b0;
      end else begin
        res.hit  = 1'b1;
        res.data = d;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_hit1  = '0;
    w_hit2  = '0;
    w_rdy1  = '1;
    w_rdy2  = '1;
    w_data1 = '0;
    w_data2 = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      {w_hit1[i], w_rdy1[i], w_data1[i]} = resolve(w_ra1[i]);
      {w_hit2[i], w_rdy2[i], w_data2[i]} = resolve(w_ra2[i]);
    end
  end

  always_comb begin
    w_raw = '0;
    for (int unsigned i = 1; i < ISSUE_W; i++) begin
      for (int unsigned k = 0; k < i; k++) begin
        if (bus.issue_valid[k] && bus.issue_regwrite[k] && (w_rdst[k] != '0) &&
            ((w_rdst[k] == w_ra1[i]) || (w_rdst[k] == w_ra2[i])))
          w_raw[i] = 1'b1;
      end
    end
  end

  always_comb begin : p_grant
    logic w_prev;
    w_ok    = '0;
    w_prev  = w_rdy1[0] & w_rdy2[0];
    w_ok[0] = w_prev;
    for (int unsigned i = 1; i < ISSUE_W; i++) begin
      if (bus.issue_valid[i])
        w_prev = w_prev & w_rdy1[i] & w_rdy2[i] & ~w_raw[i];
      w_ok[i] = w_prev;
    end
  end

  assign bus.fwd_hit1  = w_hit1;
  assign bus.fwd_hit2  = w_hit2;
  assign bus.fwd_data1 = w_data1;
  assign bus.fwd_data2 = w_data2;
  assign bus.issue_ok  = w_ok;
  assign bus.stall     = bus.issue_valid[0] & ~w_ok[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid    <= '0;
      r_regwrite <= '0;
      r_late     <= '0;
      r_rdst     <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (bus.pipe_en) begin
      r_valid[0]    <= bus.issue_valid & w_ok;
      r_regwrite[0] <= bus.issue_regwrite;
      r_late[0]     <= bus.issue_late;
      r_rdst[0]     <= w_rdst;
      for (int unsigned s = 1; s < NSTAGE; s++) begin
        r_valid[s]    <= r_valid[s-1];
        r_regwrite[s] <= r_regwrite[s-1];
        r_late[s]     <= r_late[s-1];
        r_rdst[s]     <= r_rdst[s-1];
      end
    end
  end

endmodule

// File: tb/tb_bypass_net.sv
// Self-checking bench for bypass_net: directed scenarios plus random traffic against
// a producer-list reference model (age-tagged in-flight writers).
module tb_bypass_net;
  localparam int unsigned IW = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned LS = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic resetn;

  bypass_net_if #(.ISSUE_W(IW), .NSTAGE(NS), .DATA_W(DW), .REG_AW(AW)) bus ();

  bypass_net #(.ISSUE_W(IW), .NSTAGE(NS), .LATE_STAGE(LS), .DATA_W(DW), .REG_AW(AW))
    u_dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   age;
    int unsigned   slot;
    logic [AW-1:0] rd;
    logic          late;
  } prod_t;

  prod_t q[$];

  logic          pen, fl;
  logic [IW-1:0] v, wr, lt;
  logic [AW-1:0] a1[IW], a2[IW], rd[IW];
  logic [DW-1:0] sd[NS*IW];

  logic [IW-1:0]    e_hit1, e_hit2, e_rdy1, e_rdy2, e_ok;
  logic [IW*DW-1:0] e_d1, e_d2;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] ra, output logic hit,
                                 output logic rdy, output logic [DW-1:0] d);
    int best;
    best = -1;
    hit = 1'b0; rdy = 1'b1; d = '0;
    if (ra == '0) return;
    foreach (q[j]) begin
      if (q[j].rd == ra) begin
        if (best < 0 || q[j].age < q[best].age ||
            (q[j].age == q[best].age && q[j].slot > q[best].slot))
          best = j;
      end
    end
    if (best >= 0) begin
      if (q[best].late && q[best].age < LS) rdy = 1'b0;
      else begin
        hit = 1'b1;
        d   = sd[q[best].age*IW + q[best].slot];
      end
    end
  endfunction

  task automatic model_eval();
    logic h, r, prev, raw;
    logic [DW-1:0] d;
    for (int i = 0; i < IW; i++) begin
      lookup(a1[i], h, r, d); e_hit1[i] = h; e_rdy1[i] = r; e_d1[i*DW +: DW] = d;
      lookup(a2[i], h, r, d); e_hit2[i] = h; e_rdy2[i] = r; e_d2[i*DW +: DW] = d;
    end
    prev = e_rdy1[0] & e_rdy2[0];
    e_ok[0] = prev;
    for (int i = 1; i < IW; i++) begin
      raw = 1'b0;
      for (int k = 0; k < i; k++)
        if (v[k] && wr[k] && rd[k] != '0 && (rd[k] == a1[i] || rd[k] == a2[i])) raw = 1'b1;
      if (v[i]) prev = prev && e_rdy1[i] && e_rdy2[i] && !raw;
      e_ok[i] = prev;
    end
  endtask

  task automatic model_edge();
    prod_t nq[$];
    prod_t p;
    if (!resetn || fl) begin
      q.delete();
    end else if (pen) begin
      foreach (q[j]) if (q[j].age + 1 < NS) begin
        p = q[j]; p.age++; nq.push_back(p);
      end
      for (int i = 0; i < IW; i++)
        if (v[i] && e_ok[i] && wr[i]) begin
          p.age = 0; p.slot = i; p.rd = rd[i]; p.late = lt[i];
          nq.push_back(p);
        end
      q = nq;
    end
  endtask

  task automatic drive();
    bus.pipe_en = pen; bus.flush = fl;
    bus.issue_valid = v; bus.issue_regwrite = wr; bus.issue_late = lt;
    for (int i = 0; i < IW; i++) begin
      bus.issue_ra1[i*AW +: AW]  = a1[i];
      bus.issue_ra2[i*AW +: AW]  = a2[i];
      bus.issue_rdst[i*AW +: AW] = rd[i];
    end
    for (int j = 0; j < NS*IW; j++) bus.stage_data[j*DW +: DW] = sd[j];
  endtask

  task automatic check_all();
    chk("hit1", bus.fwd_hit1, e_hit1);
    chk("hit2", bus.fwd_hit2, e_hit2);
    chk("data1", bus.fwd_data1, e_d1);
    chk("data2", bus.fwd_data2, e_d2);
    chk("issue_ok", bus.issue_ok, e_ok);
    chk("stall", bus.stall, v[0] & ~e_ok[0]);
  endtask

  task automatic cycle_pre();
    drive(); #2; model_eval(); check_all(); vectors++;
  endtask

  task automatic cycle_post();
    @(posedge clk); model_edge(); #1;
  endtask

  task automatic cycle();
    cycle_pre(); cycle_post();
  endtask

  task automatic clear_stim();
    pen = 1'b1; fl = 1'b0; v = '0; wr = '0; lt = '0;
    for (int i = 0; i < IW; i++) begin a1[i] = '0; a2[i] = '0; rd[i] = '0; end
    for (int j = 0; j < NS*IW; j++) sd[j] = $urandom;
  endtask

  task automatic rand_stim();
    pen = ($urandom_range(0, 7) != 0); fl = ($urandom_range(0, 15) == 0);
    for (int i = 0; i < IW; i++) begin
      v[i] = ($urandom_range(0, 3) != 0); wr[i] = $urandom_range(0, 1);
      lt[i] = ($urandom_range(0, 3) == 0);
      a1[i] = AW'($urandom_range(0, 7)); a2[i] = AW'($urandom_range(0, 7));
      rd[i] = AW'($urandom_range(0, 7));
    end
    for (int j = 0; j < NS*IW; j++) sd[j] = $urandom;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [AW-1:0] d, input logic w, input logic l);
    v[i] = 1'b1; a1[i] = r1; a2[i] = r2; rd[i] = d; wr[i] = w; lt[i] = l;
  endtask

  task automatic do_flush();
    clear_stim(); fl = 1'b1; cycle();
  endtask

  initial begin
    resetn = 1'b0;
    rand_stim();
    #1;
    for (int n = 0; n < 2; n++) begin
      rand_stim();
      cycle_pre();
      chk("rst_hit", {bus.fwd_hit1, bus.fwd_hit2}, '0);
      chk("rst_data", {bus.fwd_data1, bus.fwd_data2}, '0);
      cycle_post();
    end
    resetn = 1'b1;

    // ALU chain: r5 produced in slot 0, consumed next cycle from E slot 0
    clear_stim(); set_slot(0, 0, 0, 5, 1'b1, 1'b0); cycle();
    clear_stim(); set_slot(1, 5, 0, 0, 1'b0, 1'b0); sd[0] = 32'h1234;
    cycle_pre();
    chk("alu_hit", bus.fwd_hit1[1], 1'b1);
    chk("alu_data", bus.fwd_data1[DW +: DW], 32'h1234);
    cycle_post();

    // Load-use: reader held until the late tag reaches LATE_STAGE
    do_flush();
    clear_stim(); set_slot(0, 0, 0, 8, 1'b1, 1'b1); cycle();
    for (int n = 0; n < LS; n++) begin
      clear_stim(); set_slot(0, 8, 0, 0, 1'b0, 1'b0);
      cycle_pre(); chk("ld_stall", bus.stall, 1'b1); cycle_post();
    end
    clear_stim(); set_slot(0, 8, 0, 0, 1'b0, 1'b0);
    cycle_pre(); chk("ld_ok", bus.issue_ok[0], 1'b1); chk("ld_hit", bus.fwd_hit1[0], 1'b1);
    cycle_post();

    // Youngest producer wins
    do_flush();
    clear_stim(); set_slot(1, 0, 0, 3, 1'b1, 1'b0); cycle();
    clear_stim(); set_slot(0, 0, 0, 3, 1'b1, 1'b0); set_slot(1, 0, 0, 3, 1'b1, 1'b0); cycle();
    clear_stim(); set_slot(0, 3, 0, 0, 1'b0, 1'b0);
    cycle_pre();
    chk("young_hit", bus.fwd_hit1[0], 1'b1);
    chk("young_data", bus.fwd_data1[0 +: DW], sd[1]);
    cycle_post();

    // $0 never forwards
    do_flush();
    clear_stim(); set_slot(0, 0, 0, 0, 1'b1, 1'b0); cycle();
    clear_stim(); set_slot(0, 0, 0, 0, 1'b0, 1'b0);
    cycle_pre(); chk("r0_hit", {bus.fwd_hit1, bus.fwd_hit2}, '0); cycle_post();

    // Bundle split and blocked prefix
    do_flush();
    clear_stim(); set_slot(0, 0, 0, 4, 1'b1, 1'b0); set_slot(1, 4, 0, 0, 1'b0, 1'b0);
    cycle_pre(); chk("split_ok", bus.issue_ok, 2'b01); cycle_post();
    do_flush();
    clear_stim(); set_slot(0, 0, 0, 9, 1'b1, 1'b1); cycle();
    clear_stim(); set_slot(0, 9, 0, 0, 1'b0, 1'b0); set_slot(1, 1, 2, 6, 1'b1, 1'b0);
    cycle_pre(); chk("blocked_ok", bus.issue_ok, 2'b00); cycle_post();

    // Flush with all rows occupied
    do_flush();
    for (int n = 0; n < NS; n++) begin
      clear_stim(); set_slot(0, 0, 0, 10, 1'b1, 1'b1); set_slot(1, 0, 0, 11, 1'b1, 1'b0);
      cycle();
    end
    clear_stim(); set_slot(0, 0, 0, 10, 1'b1, 1'b0); fl = 1'b1; cycle();
    clear_stim(); set_slot(0, 10, 11, 0, 1'b0, 1'b0); set_slot(1, 11, 10, 0, 1'b0, 1'b0);
    cycle_pre();
    chk("flush_hit", {bus.fwd_hit1, bus.fwd_hit2}, '0);
    chk("flush_stall", bus.stall, 1'b0);
    cycle_post();

    // Random traffic with one asynchronous mid-run reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rand_stim();
        resetn = 1'b0;
        q.delete();
        drive(); #1;
        model_eval(); check_all(); vectors++;
        chk("mid_rst_hit", {bus.fwd_hit1, bus.fwd_hit2}, '0);
        chk("mid_rst_data", {bus.fwd_data1, bus.fwd_data2}, '0);
        resetn = 1'b1;
      end
      rand_stim();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
